// File: rtl/triangle_classifier.sv
// Three-stage valid/ready triangle classifier: sort, arithmetic, classify.
// Reports validity, shape, right-angle flag and perimeter, plus saturating result counters.
module triangle_classifier #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [W-1:0]      a_i,
   input  logic [W-1:0]      b_i,
   input  logic [W-1:0]      c_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_o,
   output logic [1:0]        kind_o,
   output logic              right_o,
   output logic [W+1:0]      perim_o,
   output logic [CW-1:0]     cnt_all_o,
   output logic [CW-1:0]     cnt_tri_o
);

   localparam int SW = W + 1;
   localparam int PW = W + 2;
   localparam int QW = 2 * W + 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      KIND_NONE    = 2'd0,
      KIND_SCALENE = 2'd1,
      KIND_ISO     = 2'd2,
      KIND_EQUI    = 2'd3
   } kind_e;

   logic          en;
   logic          consume;

   // Stage 1: sorted sides and equality flags
   logic [W-1:0]  lo_d, mid_d, hi_d, swap_tmp;
   logic          v1_q;
   logic [W-1:0]  lo_q, mid_q, hi_q;
   logic [2:0]    eq1_q;

   // Stage 2: arithmetic
   logic          v2_q;
   logic [SW-1:0] sum_lm_q;
   logic [PW-1:0] perim2_q;
   logic [QW-1:0] sq_lm_q, sq_h_q;
   logic [W-1:0]  hi2_q;
   logic          any_zero_q;
   logic [2:0]    eq2_q;

   // Stage 3: classification results
   logic          tri_d, right_d;
   kind_e         kind_d;
   logic          out_valid_q, out_q, right_q;
   kind_e         kind_q;
   logic [PW-1:0] perim_q;

   logic [CW-1:0] cnt_all_d, cnt_all_q, cnt_tri_d, cnt_tri_q;

   // One enable freezes every stage together, so nothing in flight can be overwritten.
   assign en      = !out_valid_q || out_ready_i;
   assign consume = out_valid_q && out_ready_i;

   // Three compare-swap steps give lo <= mid <= hi.
   always_comb begin
      // NOTE: every combinational target gets a default before any branch, so no latch is inferred.
      lo_d     = a_i;
      mid_d    = b_i;
      hi_d     = c_i;
      swap_tmp = '0;
      if (lo_d > mid_d) begin swap_tmp = lo_d;  lo_d  = mid_d; mid_d = swap_tmp; end
      if (mid_d > hi_d) begin swap_tmp = mid_d; mid_d = hi_d;  hi_d  = swap_tmp; end
      if (lo_d > mid_d) begin swap_tmp = lo_d;  lo_d  = mid_d; mid_d = swap_tmp; end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all stages sample the same old values.
         v1_q  <= 1'b0;
         lo_q  <= '0;
         mid_q <= '0;
         hi_q  <= '0;
         eq1_q <= '0;
      end else if (en) begin
         v1_q <= in_valid_i;
         if (in_valid_i) begin
            lo_q  <= lo_d;
            mid_q <= mid_d;
            hi_q  <= hi_d;
            eq1_q <= {a_i == c_i, b_i == c_i, a_i == b_i};
         end
      end
   end

   // Operands are widened before the add/multiply so no term can overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q       <= 1'b0;
         sum_lm_q   <= '0;
         perim2_q   <= '0;
         sq_lm_q    <= '0;
         sq_h_q     <= '0;
         hi2_q      <= '0;
         any_zero_q <= 1'b0;
         eq2_q      <= '0;
      end else if (en) begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum_lm_q   <= SW'(lo_q) + SW'(mid_q);
            perim2_q   <= PW'(lo_q) + PW'(mid_q) + PW'(hi_q);
            sq_lm_q    <= QW'(lo_q) * QW'(lo_q) + QW'(mid_q) * QW'(mid_q);
            sq_h_q     <= QW'(hi_q) * QW'(hi_q);
            hi2_q      <= hi_q;
            any_zero_q <= (lo_q == '0);
            eq2_q      <= eq1_q;
         end
      end
   end

   always_comb begin
      tri_d   = !any_zero_q && (sum_lm_q > SW'(hi2_q));
      right_d = tri_d && (sq_lm_q == sq_h_q);
      kind_d  = KIND_NONE;
      if (tri_d) begin
         if (eq2_q[0] && eq2_q[1])  kind_d = KIND_EQUI;
         else if (|eq2_q)           kind_d = KIND_ISO;
         else                       kind_d = KIND_SCALENE;
      end
   end

   // Result registers load only with real results; across bubbles they keep the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= 1'b0;
         kind_q      <= KIND_NONE;
         right_q     <= 1'b0;
         perim_q     <= '0;
      end else if (en) begin
         out_valid_q <= v2_q;
         if (v2_q) begin
            out_q   <= tri_d;
            kind_q  <= kind_d;
            right_q <= right_d;
            perim_q <= perim2_q;
         end
      end
   end

   always_comb begin
      cnt_all_d = cnt_all_q;
      cnt_tri_d = cnt_tri_q;
      if (clr_i) begin
         cnt_all_d = '0;
         cnt_tri_d = '0;
      end else if (consume) begin
         if (cnt_all_q != CNT_MAX)          cnt_all_d = cnt_all_q + 1'b1;
         if (out_q && cnt_tri_q != CNT_MAX) cnt_tri_d = cnt_tri_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_all_q <= '0;
         cnt_tri_q <= '0;
      end else begin
         cnt_all_q <= cnt_all_d;
         cnt_tri_q <= cnt_tri_d;
      end
   end

   assign in_ready_o  = en;
   assign out_valid_o = out_valid_q;
   assign out_o       = out_q;
   assign kind_o      = kind_q;
   assign right_o     = right_q;
   assign perim_o     = perim_q;
   assign cnt_all_o   = cnt_all_q;
   assign cnt_tri_o   = cnt_tri_q;

endmodule

// File: tb/tb_triangle_classifier.sv
// Self-checking bench for triangle_classifier: directed table, handshake corner cases and
// randomized traffic scored against a plain-arithmetic reference model.
module tb_triangle_classifier;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic       out;
      logic [1:0] kind;
      logic       right;
      logic [9:0] perim;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = '0, b = '0, c = '0;

   logic        in_ready, out_valid, out_bit, right_bit;
   logic [1:0]  kind;
   logic [9:0]  perim;
   logic [15:0] cnt_all, cnt_tri;

   logic        in_ready2, out_valid2, out_bit2, right_bit2;
   logic [1:0]  kind2;
   logic [9:0]  perim2;
   logic [1:0]  cnt_all2, cnt_tri2;

   int   checks = 0;
   int   fails  = 0;
   vec_t drv_exp;
   vec_t exp_q[$];
   int   m_all = 0, m_tri = 0;

   always #5 clk = ~clk;

   triangle_classifier #(.W(8), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .c_i(c), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_o(out_bit), .kind_o(kind), .right_o(right_bit), .perim_o(perim),
      .cnt_all_o(cnt_all), .cnt_tri_o(cnt_tri));

   // Narrow-counter instance sharing the same stimulus, used for saturation checks.
   triangle_classifier #(.W(8), .CW(2)) u_dut_cw2 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready2),
      .a_i(a), .b_i(b), .c_i(c), .out_valid_o(out_valid2), .out_ready_i(out_ready),
      .out_o(out_bit2), .kind_o(kind2), .right_o(right_bit2), .perim_o(perim2),
      .cnt_all_o(cnt_all2), .cnt_tri_o(cnt_tri2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int m, input int mx);
      return (m > mx) ? mx : m;
   endfunction

   // Reference: all three triangle inequalities on the unsorted sides, count equal pairs,
   // and try Pythagoras with each side as hypotenuse.
   function automatic vec_t model(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sc);
      vec_t r;
      int x = int'(sa);
      int y = int'(sb);
      int z = int'(sc);
      int eqs = 0;
      r.a = sa; r.b = sb; r.c = sc;
      r.perim = 10'(x + y + z);
      r.out = (x + y > z) && (x + z > y) && (y + z > x);
      if (x == y) eqs++;
      if (y == z) eqs++;
      if (x == z) eqs++;
      if (!r.out)       r.kind = 2'd0;
      else if (eqs == 3) r.kind = 2'd3;
      else if (eqs > 0)  r.kind = 2'd2;
      else               r.kind = 2'd1;
      r.right = r.out && ((x*x + y*y == z*z) || (x*x + z*z == y*y) || (y*y + z*z == x*x));
      return r;
   endfunction

   // Scoreboard: pop on consumption, push on acceptance, track counters every cycle.
   always @(negedge clk) begin
      vec_t e;
      if (!rst_n) begin
         exp_q.delete();
         m_all = 0;
         m_tri = 0;
      end else begin
         check("cnt_all", 32'(cnt_all), 32'(sat(m_all, 65535)));
         check("cnt_tri", 32'(cnt_tri), 32'(sat(m_tri, 65535)));
         check("cnt_all_cw2", 32'(cnt_all2), 32'(sat(m_all, 3)));
         check("cnt_tri_cw2", 32'(cnt_tri2), 32'(sat(m_tri, 3)));
         e = '0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out", 32'(out_bit), 32'(e.out));
               check("kind", 32'(kind), 32'(e.kind));
               check("right", 32'(right_bit), 32'(e.right));
               check("perim", 32'(perim), 32'(e.perim));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(drv_exp);
         if (clr) begin
            m_all = 0;
            m_tri = 0;
         end else if (out_valid && out_ready) begin
            m_all++;
            if (e.out) m_tri++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v, output int waits);
      logic acc;
      acc = 1'b0;
      waits = 0;
      in_valid = 1'b1;
      a = v.a; b = v.b; c = v.c;
      drv_exp = v;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) break;
         waits++;
      end
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100; k++) begin
         if (!out_valid && exp_q.size() == 0) break;
         tick();
      end
      check("drain_timeout", 32'(k < 100), 32'd1);
   endtask

   function automatic vec_t mk(input int sa, input int sb, input int sc, input int o,
                               input int k, input int r, input int p);
      vec_t v;
      v.a = 8'(sa); v.b = 8'(sb); v.c = 8'(sc);
      v.out = 1'(o); v.kind = 2'(k); v.right = 1'(r); v.perim = 10'(p);
      return v;
   endfunction

   function automatic logic [7:0] rand_side();
      if ($urandom % 4 == 0) return 8'($urandom_range(0, 5));
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      vec_t tbl[10];
      vec_t v;
      int   w;
      logic [9:0] hold_perim;
      logic [1:0] hold_kind;
      logic       hold_out;
      logic       acc_last;

      tbl[0] = mk(3,   4,   5,   1, 1, 1, 12);
      tbl[1] = mk(0,   0,   0,   0, 0, 0, 0);
      tbl[2] = mk(10,  100, 255, 0, 0, 0, 365);
      tbl[3] = mk(1,   1,   1,   1, 3, 0, 3);
      tbl[4] = mk(1,   127, 255, 0, 0, 0, 383);
      tbl[5] = mk(0,   128, 127, 0, 0, 0, 255);
      tbl[6] = mk(255, 128, 128, 1, 2, 0, 511);
      tbl[7] = mk(5,   3,   2,   0, 0, 0, 10);
      tbl[8] = mk(13,  5,   12,  1, 1, 1, 30);
      tbl[9] = mk(2,   2,   3,   1, 2, 0, 7);

      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out_bit), 32'd0);
      check("rst_kind", 32'(kind), 32'd0);
      check("rst_right", 32'(right_bit), 32'd0);
      check("rst_perim", 32'(perim), 32'd0);
      check("rst_cnt_all", 32'(cnt_all), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      // Latency: result visible after the third edge counted from the accepting edge
      send(tbl[0], w);
      check("lat_valid_0", 32'(out_valid), 32'd0);
      tick();
      check("lat_valid_1", 32'(out_valid), 32'd0);
      tick();
      check("lat_valid_2", 32'(out_valid), 32'd1);
      check("lat_perim", 32'(perim), 32'd12);
      check("lat_right", 32'(right_bit), 32'd1);
      tick();
      check("lat_cnt_all", 32'(cnt_all), 32'd1);
      check("lat_cnt_tri", 32'(cnt_tri), 32'd1);

      // Back-to-back table stream, one accept per cycle
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         send(tbl[i], w);
         check("b2b_accept_wait", 32'(w), 32'd0);
      end
      drain();
      check("b2b_cnt_all", 32'(cnt_all), 32'd6);
      check("b2b_cnt_tri", 32'(cnt_tri), 32'd2);

      // Degenerate then permuted right triangle
      for (int i = 7; i <= 8; i++) send(tbl[i], w);
      drain();

      // Backpressure with a CLR pulse inside the stall
      clr = 1'b1; tick(); clr = 1'b0;
      send(model(6, 8, 10), w);
      send(model(7, 7, 7), w);
      send(model(9, 9, 2), w);
      out_ready = 1'b0;
      v = model(20, 21, 29);
      in_valid = 1'b1; a = v.a; b = v.b; c = v.c; drv_exp = v;
      hold_perim = perim; hold_kind = kind; hold_out = out_bit;
      check("bp_first_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         clr = (k == 2);
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_perim", 32'(perim), 32'(hold_perim));
         check("bp_hold_kind", 32'(kind), 32'(hold_kind));
         check("bp_hold_out", 32'(out_bit), 32'(hold_out));
         tick();
      end
      clr = 1'b0;
      out_ready = 1'b1;
      send(v, w);
      drain();
      check("bp_cnt_all", 32'(cnt_all), 32'd4);

      // Saturation on the narrow counters, then CLR colliding with a consumption
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 0; i < 5; i++) send(model(8'(3 + i), 8'(4 + i), 8'(5 + i)), w);
      drain();
      check("sat_cnt_all_cw2", 32'(cnt_all2), 32'd3);
      check("sat_cnt_tri_cw2", 32'(cnt_tri2), 32'd3);
      check("sat_cnt_all", 32'(cnt_all), 32'd5);
      send(model(5, 5, 5), w);
      for (int k = 0; k < 10; k++) begin
         if (out_valid) break;
         tick();
      end
      check("clr_consume_valid", 32'(out_valid), 32'd1);
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_consume_all", 32'(cnt_all), 32'd0);
      check("clr_consume_tri", 32'(cnt_tri), 32'd0);
      check("clr_consume_all_cw2", 32'(cnt_all2), 32'd0);

      // Reset with three triples in flight
      send(model(4, 4, 4), w);
      drain();
      check("pre_rst_cnt_all", 32'(cnt_all), 32'd1);
      send(model(3, 4, 5), w);
      send(model(6, 6, 1), w);
      send(model(9, 1, 1), w);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_cnt_all", 32'(cnt_all), 32'd0);
      check("mid_rst_cnt_tri", 32'(cnt_tri), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      send(tbl[9], w);
      drain();
      check("post_rst_kind", 32'(kind), 32'd2);
      check("post_rst_out", 32'(out_bit), 32'd1);

      // Randomized traffic with random backpressure
      acc_last = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         out_ready = ($urandom % 4) != 0;
         if (!in_valid || acc_last) begin
            in_valid = ($urandom % 3) != 0;
            if ($urandom % 8 == 0) begin
               case ($urandom % 5)
                  0: begin a = 3;  b = 4;  c = 5;  end
                  1: begin a = 13; b = 12; c = 5;  end
                  2: begin a = 15; b = 17; c = 8;  end
                  3: begin a = 24; b = 25; c = 7;  end
                  default: begin a = 29; b = 20; c = 21; end
               endcase
            end else begin
               a = rand_side(); b = rand_side(); c = rand_side();
            end
            drv_exp = model(a, b, c);
         end
         @(negedge clk);
         acc_last = in_valid && in_ready;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
